// File: rtl/axi_rd_arbiter.sv
// Two-requester (inst/data) read arbiter in front of a single AXI read bridge.
// One transaction in flight; data has priority, with a starvation guard for inst.
module axi_rd_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inst_rd_req,
  input  logic [1:0]   inst_rd_type,
  input  logic [31:0]  inst_rd_addr,
  output logic         inst_rd_rdy,
  output logic         inst_ret_valid,
  output logic [511:0] inst_ret_data,
  output logic         inst_ret_half,
  input  logic         data_rd_req,
  input  logic [1:0]   data_rd_type,
  input  logic [31:0]  data_rd_addr,
  output logic         data_rd_rdy,
  output logic         data_ret_valid,
  output logic [511:0] data_ret_data,
  output logic         data_ret_half,
  output logic         axi_rd_req,
  output logic [1:0]   axi_rd_type,
  output logic [31:0]  axi_rd_addr,
  input  logic         axi_rd_rdy,
  input  logic         axi_ret_valid,
  input  logic [511:0] axi_ret_data,
  input  logic         axi_ret_half
);

  localparam logic [2:0] ST_IDLE    = 3'b001;
  localparam logic [2:0] ST_REQ     = 3'b010;
  localparam logic [2:0] ST_WAIT    = 3'b100;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic        r_owner;        // 0 = inst, 1 = data
  logic [1:0]  r_type;
  logic [31:0] r_addr;
  logic [2:0]  r_starve_cnt;

  logic w_grant;
  logic w_grant_inst;
  logic w_starve_hit;

  assign w_starve_hit = (r_starve_cnt == STARVE_LIM);
  assign w_grant      = (r_state == ST_IDLE) && (inst_rd_req || data_rd_req);
  assign w_grant_inst = inst_rd_req && (!data_rd_req || w_starve_hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (inst_rd_req || data_rd_req) w_state_next = ST_REQ;
      ST_REQ:  if (axi_rd_rdy) w_state_next = ST_WAIT;
      ST_WAIT: if (axi_ret_valid && !axi_ret_half) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_rd_req     = 1'b0;
    inst_rd_rdy    = 1'b0;
    data_rd_rdy    = 1'b0;
    inst_ret_valid = 1'b0;
    data_ret_valid = 1'b0;
    inst_ret_half  = 1'b0;
    data_ret_half  = 1'b0;
    case (r_state)
      ST_REQ: begin
        axi_rd_req  = 1'b1;
        inst_rd_rdy = !r_owner && axi_rd_rdy;
        data_rd_rdy =  r_owner && axi_rd_rdy;
      end
      ST_WAIT: begin
        inst_ret_valid = !r_owner && axi_ret_valid;
        data_ret_valid =  r_owner && axi_ret_valid;
        inst_ret_half  = !r_owner && axi_ret_half;
        data_ret_half  =  r_owner && axi_ret_half;
      end
      default: ;
    endcase
  end

  assign axi_rd_type   = r_type;
  assign axi_rd_addr   = r_addr;
  assign inst_ret_data = axi_ret_data;
  assign data_ret_data = axi_ret_data;

  // Request details are captured at grant so the bridge sees a stable copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner      <= 1'b0;
      r_type       <= 2'b00;
      r_addr       <= 32'h0;
      r_starve_cnt <= 3'd0;
    end else if (w_grant) begin
      r_owner <= !w_grant_inst;
      r_type  <= w_grant_inst ? inst_rd_type : data_rd_type;
      r_addr  <= w_grant_inst ? inst_rd_addr : data_rd_addr;
      if (w_grant_inst) begin
        r_starve_cnt <= 3'd0;
      end else if (inst_rd_req && !w_starve_hit) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end

endmodule
